alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares one combinational 32-bit ALU between two requesters (e.g. execute-stage issue port and an address/multiply helper).
- Each requester has a valid/ready request channel and a valid/ready response channel.
- Arbitrates round-robin, registers operands, drives the shared ALU, registers result and zero flag, returns them to the granted requester.
- Sits between the requesters and the ALU instance; the ALU stays purely combinational.

Parameters:
- DATA_W, 32, operand/result width.
- CTRL_W, 3, ALU control width.
- IDLE_CTRL, 3'b000, ALU control driven when no operation is in flight (ALU pass-through of data1).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- req0_valid_i  in  1  requester 0 has an operation.
- req0_ready_o  out  1  requester 0 operation accepted this cycle.
- req0_data1_i  in  DATA_W  operand 1.
- req0_data2_i  in  DATA_W  operand 2.
- req0_ctrl_i  in  CTRL_W  ALU op code.
- rsp0_valid_o  out  1  result for requester 0 valid.
- rsp0_ready_i  in  1  requester 0 takes result.
- rsp0_data_o  out  DATA_W  result.
- rsp0_zero_o  out  1  result == 0.
- req1_*/rsp1_*: same set as requester 0, for requester 1.
- alu_data1_o  out  DATA_W  to ALU operand 1.
- alu_data2_o  out  DATA_W  to ALU operand 2.
- alu_ctrl_o  out  CTRL_W  to ALU op select.
- alu_data_i  in  DATA_W  ALU result.
- alu_zero_i  in  1  ALU zero flag.
- busy_o  out  1  high in ISSUE or RESP.

Behaviour:
- Reset (async, rst_n_i=0):
  - State=IDLE; all ready/valid outputs 0; rsp data/zero 0.
  - Operand registers 0; alu_ctrl_o=IDLE_CTRL; last_grant=1, so requester 0 wins first.
- FSM: IDLE -> ISSUE -> RESP -> IDLE.
- IDLE:
  - Winner selection: if only one reqN_valid_i is high, it wins. If both are high, the requester other than last_grant wins.
  - reqN_ready_o for the winner is high combinationally in the same cycle; the loser's ready stays 0.
  - On the edge: capture data1/data2/ctrl and winner id; go to ISSUE.
  - No valid: stay in IDLE.
  - ready never asserts outside IDLE.
- ISSUE (1 cycle):
  - alu_*_o driven from the operand registers.
  - On the edge: capture alu_data_i and alu_zero_i into the result registers; go to RESP.
- RESP:
  - rspN_valid_o=1 for the granted id only; data and zero held stable.
  - Stay in RESP until rspN_ready_i=1.
  - On that edge: clear valid, set last_grant=id, go to IDLE.
- ALU drive outside ISSUE/RESP: alu_data1_o/alu_data2_o=0, alu_ctrl_o=IDLE_CTRL.
- Latency and throughput:
  - Accept at edge T; rsp valid from T+2.
  - One operation per 3 cycles minimum; no overlap.
- The block does not interpret ctrl codes; widths pass through unchanged. Zero is taken from the ALU, not recomputed.
- Boundary conditions:
  - Request valid dropped before acceptance: no effect.
  - Requester held off by backpressure on the other requester's response: waits; its valid must stay asserted.
  - Reset mid-ISSUE/RESP: operation dropped, no response emitted, arbitration pointer returns to reset value.
  - Same requester issues back-to-back with the other idle: it is granted every time; round-robin applies only under contention.

Optional Feature:
- Macro ALU_ARB_FIXED_PRIO_EN.
- Defined: requester 0 always wins under contention; last_grant is ignored.
- Undefined: round-robin as above.
- All other timing is identical in both builds.

Test Plan:
- req0 add: ctrl=3'b001, 5+3 accepted at T -> rsp0_valid_o from T+2, data=8, zero=0; rsp1_valid_o stays 0.
- Contention:
  - req0 sub 7-7 and req1 or 0xF0|0x0F both valid -> req0 granted first, rsp0 data=0, zero=1.
  - Then req1 granted, rsp1 data=0xFF.
- Follow-up contention after req1 served last: both valid -> req0 wins; after req0 is served with both still valid -> req1 wins (alternation).
- Backpressure: rsp1_ready_i low for 4 cycles -> rsp1 data/zero stable; req0_ready_o stays 0 throughout; req0 accepted the cycle after rsp1 handshake.
- Reset: rst_n_i low during ISSUE -> all valids/readys 0 asynchronously; no response after release; next contention grants req0.
- With ALU_ARB_FIXED_PRIO_EN: three consecutive contended rounds -> req0 granted every round; req1 only when req0 idle.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - two-requester round-robin arbiter in front of one shared combinational ALU
//
// Purpose:
//   Accepts one operation at a time from requester 0 or 1 and registers its
//   operands. It drives the shared ALU for one cycle and registers the result
//   and zero flag. It then holds the response for the granted requester until
//   that requester takes it. Operation sequence: IDLE -> ISSUE -> RESP -> IDLE.
//
// Configuration:
//   ALU_ARB_FIXED_PRIO_EN - when defined, requester 0 always wins under
//   contention. When undefined, the requester not served last wins.
//
// Ports:
//   clk_i, rst_n_i                  clock (rising edge), asynchronous active-low reset
//   reqN_valid_i / reqN_ready_o     request handshake per requester (ready is combinational in IDLE)
//   reqN_data1_i, reqN_data2_i      operands
//   reqN_ctrl_i                     ALU op code, passed through uninterpreted
//   rspN_valid_o / rspN_ready_i     response handshake per requester
//   rspN_data_o, rspN_zero_o        registered ALU result and zero flag
//   alu_data1_o, alu_data2_o        operands to the shared ALU
//   alu_ctrl_o                      op select to the shared ALU
//   alu_data_i, alu_zero_i          result and zero flag from the shared ALU
//   busy_o                          an operation is in flight (ISSUE or RESP)
module alu_share_arbiter #(
   parameter int                 DATA_W    = 32,
   parameter int                 CTRL_W    = 3,
   parameter logic [CTRL_W-1:0]  IDLE_CTRL = '0
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              req0_valid_i,
   output logic              req0_ready_o,
   input  logic [DATA_W-1:0] req0_data1_i,
   input  logic [DATA_W-1:0] req0_data2_i,
   input  logic [CTRL_W-1:0] req0_ctrl_i,
   output logic              rsp0_valid_o,
   input  logic              rsp0_ready_i,
   output logic [DATA_W-1:0] rsp0_data_o,
   output logic              rsp0_zero_o,
   input  logic              req1_valid_i,
   output logic              req1_ready_o,
   input  logic [DATA_W-1:0] req1_data1_i,
   input  logic [DATA_W-1:0] req1_data2_i,
   input  logic [CTRL_W-1:0] req1_ctrl_i,
   output logic              rsp1_valid_o,
   input  logic              rsp1_ready_i,
   output logic [DATA_W-1:0] rsp1_data_o,
   output logic              rsp1_zero_o,
   output logic [DATA_W-1:0] alu_data1_o,
   output logic [DATA_W-1:0] alu_data2_o,
   output logic [CTRL_W-1:0] alu_ctrl_o,
   input  logic [DATA_W-1:0] alu_data_i,
   input  logic              alu_zero_i,
   output logic              busy_o
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

   state_t             state_q, state_d;
   logic [DATA_W-1:0]  op1_q, op1_d;
   logic [DATA_W-1:0]  op2_q, op2_d;
   logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
   logic               id_q, id_d;
   logic [DATA_W-1:0]  res_q, res_d;
   logic               zero_q, zero_d;
   logic               last_grant_q, last_grant_d;
   logic               pick1;
   logic               any_valid;
   logic               rsp_taken;
   logic               in_idle;
   logic               drive_alu;

   // Winner for the current cycle: 1 selects requester 1, 0 selects requester 0.
   // This value is meaningful only when at least one request is valid.
`ifdef ALU_ARB_FIXED_PRIO_EN
   assign pick1 = req1_valid_i && !req0_valid_i;
`else
   assign pick1 = req1_valid_i && (!req0_valid_i || !last_grant_q);
`endif

   assign any_valid = req0_valid_i || req1_valid_i;
   assign rsp_taken = id_q ? rsp1_ready_i : rsp0_ready_i;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q      <= S_IDLE;
         op1_q        <= '0;
         op2_q        <= '0;
         ctrl_q       <= IDLE_CTRL;
         id_q         <= 1'b0;
         res_q        <= '0;
         zero_q       <= 1'b0;
         last_grant_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         op1_q        <= op1_d;
         op2_q        <= op2_d;
         ctrl_q       <= ctrl_d;
         id_q         <= id_d;
         res_q        <= res_d;
         zero_q       <= zero_d;
         last_grant_q <= last_grant_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      op1_d        = op1_q;
      op2_d        = op2_q;
      ctrl_d       = ctrl_q;
      id_d         = id_q;
      res_d        = res_q;
      zero_d       = zero_q;
      last_grant_d = last_grant_q;
      case (state_q)
         S_IDLE: begin
            if (any_valid) begin
               state_d = S_ISSUE;
               id_d    = pick1;
               op1_d   = pick1 ? req1_data1_i : req0_data1_i;
               op2_d   = pick1 ? req1_data2_i : req0_data2_i;
               ctrl_d  = pick1 ? req1_ctrl_i  : req0_ctrl_i;
            end
         end
         S_ISSUE: begin
            res_d   = alu_data_i;
            zero_d  = alu_zero_i;
            state_d = S_RESP;
         end
         S_RESP: begin
            if (rsp_taken) begin
               last_grant_d = id_q;
               state_d      = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Ready is gated by rst_n_i. Reset forces the state to IDLE, and without
   // the gate a held request valid would raise ready while reset is asserted.
   assign in_idle      = (state_q == S_IDLE) && rst_n_i;
   assign req0_ready_o = in_idle && req0_valid_i && !pick1;
   assign req1_ready_o = in_idle && pick1;

   assign rsp0_valid_o = (state_q == S_RESP) && !id_q;
   assign rsp1_valid_o = (state_q == S_RESP) &&  id_q;
   assign rsp0_data_o  = res_q;
   assign rsp1_data_o  = res_q;
   assign rsp0_zero_o  = zero_q;
   assign rsp1_zero_o  = zero_q;

   // The ALU sees the registered operands for the whole operation. It sees a
   // quiet pass-through pattern when no operation is in flight.
   assign drive_alu   = (state_q != S_IDLE);
   assign alu_data1_o = drive_alu ? op1_q  : '0;
   assign alu_data2_o = drive_alu ? op2_q  : '0;
   assign alu_ctrl_o  = drive_alu ? ctrl_q : IDLE_CTRL;
   assign busy_o      = drive_alu;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - self-checking bench for alu_share_arbiter
module tb_alu_share_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_zero;
   logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_zero;
   logic [31:0] req0_data1, req0_data2, req1_data1, req1_data2, rsp0_data, rsp1_data;
   logic [2:0]  req0_ctrl, req1_ctrl, alu_ctrl;
   logic [31:0] alu_data1, alu_data2, alu_data;
   logic        alu_zero, busy;

   always #5 clk = ~clk;

   // Stand-in ALU: 0 pass a, 1 add, 2 sub, 3 or, 4 and, 5 xor, 6 slt, 7 not a
   function automatic logic [31:0] alu_fn(input logic [2:0] c, input logic [31:0] x, input logic [31:0] y);
      case (c)
         3'd0: return x;
         3'd1: return x + y;
         3'd2: return x - y;
         3'd3: return x | y;
         3'd4: return x & y;
         3'd5: return x ^ y;
         3'd6: return (x < y) ? 32'd1 : 32'd0;
         default: return ~x;
      endcase
   endfunction

   assign alu_data = alu_fn(alu_ctrl, alu_data1, alu_data2);
   assign alu_zero = (alu_data == 32'd0);

   alu_share_arbiter dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .req0_valid_i(req0_valid), .req0_ready_o(req0_ready),
      .req0_data1_i(req0_data1), .req0_data2_i(req0_data2), .req0_ctrl_i(req0_ctrl),
      .rsp0_valid_o(rsp0_valid), .rsp0_ready_i(rsp0_ready),
      .rsp0_data_o(rsp0_data), .rsp0_zero_o(rsp0_zero),
      .req1_valid_i(req1_valid), .req1_ready_o(req1_ready),
      .req1_data1_i(req1_data1), .req1_data2_i(req1_data2), .req1_ctrl_i(req1_ctrl),
      .rsp1_valid_o(rsp1_valid), .rsp1_ready_i(rsp1_ready),
      .rsp1_data_o(rsp1_data), .rsp1_zero_o(rsp1_zero),
      .alu_data1_o(alu_data1), .alu_data2_o(alu_data2), .alu_ctrl_o(alu_ctrl),
      .alu_data_i(alu_data), .alu_zero_i(alu_zero),
      .busy_o(busy)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Driver state: a pending op per requester, held until the model sees it accepted
   logic [1:0]  dv, dr;
   logic [31:0] da [2];
   logic [31:0] db [2];
   logic [2:0]  dc [2];

   // Transaction-level model: age of the op in flight (-1 none), its owner and result
   int          m_age  = -1;
   logic        m_id   = 1'b0;
   logic        m_last = 1'b1;
   logic [2:0]  m_c;
   logic [31:0] m_a, m_b, m_res;
   int          grants [2];

   task automatic arm(input int n, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
      dv[n] = 1'b1; dc[n] = c; da[n] = a; db[n] = b;
   endtask

   task automatic apply_inputs();
      req0_valid = dv[0]; req0_data1 = da[0]; req0_data2 = db[0]; req0_ctrl = dc[0];
      req1_valid = dv[1]; req1_data1 = da[1]; req1_data2 = db[1]; req1_ctrl = dc[1];
      rsp0_ready = dr[0]; rsp1_ready = dr[1];
   endtask

   task automatic step();
      logic win;
      logic in_flight;
      logic resp;
      @(negedge clk);
      apply_inputs();
      #1;
      // Under contention the requester not served last wins (requester 0 in fixed-priority builds)
`ifdef ALU_ARB_FIXED_PRIO_EN
      win = (dv == 2'b10);
`else
      win = (dv == 2'b10) || (dv == 2'b11 && m_last == 1'b0);
`endif
      in_flight = (m_age >= 0);
      resp      = (m_age >= 1);
      chk("req0_ready", {31'b0, req0_ready}, {31'b0, !in_flight && dv[0] && !win});
      chk("req1_ready", {31'b0, req1_ready}, {31'b0, !in_flight && dv[1] && win});
      chk("busy", {31'b0, busy}, {31'b0, in_flight});
      chk("rsp0_valid", {31'b0, rsp0_valid}, {31'b0, resp && !m_id});
      chk("rsp1_valid", {31'b0, rsp1_valid}, {31'b0, resp && m_id});
      chk("alu_ctrl", {29'b0, alu_ctrl}, in_flight ? {29'b0, m_c} : 32'd0);
      if (m_age == 0) begin
         chk("alu_data1", alu_data1, m_a);
         chk("alu_data2", alu_data2, m_b);
      end
      if (resp) begin
         chk("rsp_data", m_id ? rsp1_data : rsp0_data, m_res);
         chk("rsp_zero", {31'b0, m_id ? rsp1_zero : rsp0_zero}, {31'b0, m_res == 32'd0});
      end
      if (!in_flight && dv != 2'b00) begin
         m_id = win; m_a = da[win]; m_b = db[win]; m_c = dc[win];
         m_res = alu_fn(m_c, m_a, m_b);
         m_age = 0;
         dv[win] = 1'b0;
         grants[win]++;
      end else if (m_age == 0) begin
         m_age = 1;
      end else if (resp && dr[m_id]) begin
         m_last = m_id;
         m_age  = -1;
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_reset();
      @(negedge clk);
      apply_inputs();
      #2 rst_n = 1'b0;
      #1;
      chk("rst_req0_ready", {31'b0, req0_ready}, 32'd0);
      chk("rst_req1_ready", {31'b0, req1_ready}, 32'd0);
      chk("rst_rsp0_valid", {31'b0, rsp0_valid}, 32'd0);
      chk("rst_rsp1_valid", {31'b0, rsp1_valid}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_rsp_data", rsp0_data, 32'd0);
      chk("rst_alu_ctrl", {29'b0, alu_ctrl}, 32'd0);
      chk("rst_alu_data1", alu_data1, 32'd0);
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rst_n = 1'b1;
      m_age  = -1;
      m_last = 1'b1;
   endtask

   initial begin
      dv = 2'b00; dr = 2'b11;
      for (int i = 0; i < 2; i++) begin da[i] = '0; db[i] = '0; dc[i] = '0; grants[i] = 0; end
      rst_n = 1'b1;
      apply_inputs();
      do_reset();

      // Single add on requester 0: 5 + 3
      arm(0, 3'd1, 32'd5, 32'd3);
      run(6);

      // Contention: sub 7-7 on requester 0 against or F0|0F on requester 1
      arm(0, 3'd2, 32'd7, 32'd7);
      arm(1, 3'd3, 32'hF0, 32'h0F);
      run(10);

      // Requester 1 was served last, so requester 0 wins; then they alternate
      arm(0, 3'd1, 32'd1, 32'd2);
      arm(1, 3'd5, 32'hAA, 32'h55);
      run(4);
      arm(0, 3'd4, 32'hFF00, 32'h0FF0);
      run(12);

      // Backpressure on requester 1's response while requester 0 waits
      dr[1] = 1'b0;
      arm(1, 3'd2, 32'd9, 32'd4);
      run(2);
      arm(0, 3'd1, 32'd100, 32'd23);
      run(5);
      dr[1] = 1'b1;
      run(8);

      // Back-to-back operations from requester 0 with requester 1 idle
      for (int k = 0; k < 3; k++) begin
         arm(0, 3'd1, 32'(k), 32'd10);
         run(3);
      end
      run(2);

      // Reset while an op is in ISSUE: the op is dropped and requester 0 wins next
      arm(0, 3'd1, 32'd40, 32'd2);
      run(1);
      do_reset();
      run(4);
      arm(0, 3'd3, 32'h1, 32'h2);
      arm(1, 3'd3, 32'h4, 32'h8);
      run(10);

      // Randomized traffic with random response backpressure and request drops
      for (int it = 0; it < 3000; it++) begin
         for (int n = 0; n < 2; n++) begin
            if (!dv[n] && $urandom_range(0, 2) == 0) begin
               logic [31:0] a;
               a = $urandom;
               arm(n, 3'($urandom_range(0, 7)), a, ($urandom_range(0, 3) == 0) ? a : $urandom);
            end else if (dv[n] && $urandom_range(0, 19) == 0) begin
               dv[n] = 1'b0;
            end
            dr[n] = ($urandom_range(0, 3) != 0);
         end
         if ($urandom_range(0, 299) == 0) do_reset();
         else step();
      end

      chk("grants0_seen", {31'b0, grants[0] > 20}, 32'd1);
      chk("grants1_seen", {31'b0, grants[1] > 20}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
